pipeline_lane: RTL

Per-pipeline feed lane sitting directly upstream of the shared resource: a DEPTH-stage lockstep register pipeline that accepts beats from a source, carries data plus a flush marker, and presents its head beat to the shared resource's `in_data_N / in_valid_N / in_flush_N` inputs. All stages freeze together while the shared resource asserts `global_stall`; there is no skid buffer. One instance exists per pipeline (two in the current design). A separate kill input squashes all in-flight beats.

---
 rtl/lane_pkg.sv | 14 +
 rtl/lane_stage_reg.sv | 55 +++++
 rtl/pipeline_lane.sv | 112 +++++++++++
 3 files changed

// File: rtl/lane_pkg.sv
// Shared definitions for the pipeline feed lane: default beat width,
// the beat record and the stall counter width.
package lane_pkg;

  localparam int LANE_DATA_W = 32;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic                   valid;
    logic                   flush;
    logic [LANE_DATA_W-1:0] data;
  } lane_beat_t;

endpackage

// File: rtl/lane_stage_reg.sv
// One lockstep stage of the feed lane: clear beats load beats hold.
// An invalid beat is always stored as all-zero flush and data.
module lane_stage_reg
  import lane_pkg::*;
#(
  parameter int DATA_W = LANE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              flush_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    flush_d = flush_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      flush_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      flush_d = valid_i & flush_i;
      data_d  = valid_i ? data_i : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      flush_q <= flush_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign flush_o = flush_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_lane.sv
// DEPTH-stage lockstep feed lane in front of the shared resource; head beat
// is driven straight from registers. Stall counter: PIPELINE_LANE_STALL_CNT_EN.
module pipeline_lane
  import lane_pkg::*;
#(
  parameter int  DATA_W = LANE_DATA_W,
  parameter int  DEPTH  = 3,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      src_data,
  input  logic                   src_valid,
  input  logic                   src_flush,
  output logic                   src_ready,
  input  logic                   kill,
  input  logic                   global_stall,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_flush,
  output logic [OCC_W-1:0]       occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic              advance;
  logic              load;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  flush_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;

  assign advance   = !global_stall;
  assign load      = advance && !kill;
  assign src_ready = load;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic              v_in;
    logic              f_in;
    logic [DATA_W-1:0] d_in;

    if (gi == 0) begin : g_entry
      assign v_in = src_valid;
      assign f_in = src_valid & src_flush;
      assign d_in = src_valid ? src_data : '0;
    end else begin : g_chain
      assign v_in = valid_q[gi-1];
      assign f_in = flush_q[gi-1];
      assign d_in = data_q[gi-1];
    end

    lane_stage_reg #(.DATA_W(DATA_W)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear_i (kill),
      .load_i  (load),
      .valid_i (v_in),
      .flush_i (f_in),
      .data_i  (d_in),
      .valid_o (valid_q[gi]),
      .flush_o (flush_q[gi]),
      .data_o  (data_q[gi])
    );
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_flush = flush_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // On advance the head leaves and the source beat (if any) enters.
  always_comb begin
    occ_d = occ_q;
    if (kill) begin
      occ_d = '0;
    end else if (advance) begin
      occ_d = occ_q - OCC_W'(valid_q[DEPTH-1]) + OCC_W'(src_valid);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifdef PIPELINE_LANE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (global_stall && out_valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
